alu_operand_stage: RTL and testbench

//  Decode/operand stage directly upstream of the single-cycle core ALU. Accepts one RV32I

---
 rtl/riscv_isa.sv | 23 ++
 rtl/reg_file.sv | 23 ++
 rtl/alu_operand_stage.sv | 80 ++++++++
 tb/tb_alu_operand_stage.sv | 117 +++++++++++
 4 files changed

// File: rtl/riscv_isa.sv
// riscv_isa: RV32I opcode/funct3 constants, ALU opcode type and immediate helpers.
package riscv_isa;
  typedef logic [3:0] alu_op_t;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam alu_op_t ALU_ADD = 4'b0000;
  function automatic logic [31:0] imm_i(input logic [11:0] f);
    return {{20{f[11]}}, f};
  endfunction
  function automatic logic [31:0] imm_u(input logic [19:0] f);
    return {f, 12'b0};
  endfunction
endpackage

// File: rtl/reg_file.sv
// reg_file: 2 async read / 1 sync write register file, x0 hardwired to zero, write-first bypass.
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);
  logic [XLEN-1:0] mem [NREG];
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) for (int i = 0; i < NREG; i++) mem[i] <= '0;
    else if (we && waddr != '0) mem[waddr] <= wdata;
  assign rdata1 = raddr1 == '0 ? '0 : (we && waddr == raddr1) ? wdata : mem[raddr1];
  assign rdata2 = raddr2 == '0 ? '0 : (we && waddr == raddr2) ? wdata : mem[raddr2];
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: RV32I decode/operand stage with busy-bit scoreboard feeding the ALU.
module alu_operand_stage
  import riscv_isa::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output alu_op_t         alu_opcode,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_illegal
);
  logic [XLEN-1:0] rdata1, rdata2, d_src1, d_src2;
  logic [NREG-1:0] busy, pend, wb_clr;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] f3;
  logic is_op, is_imm, is_lui, is_auipc, illegal, d_we, hazard, accept;
  alu_op_t d_op;
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign rd = in_instr[11:7];
  assign f3 = in_instr[14:12];
  assign is_op = in_instr[6:0] == OPC_OP;
  assign is_imm = in_instr[6:0] == OPC_OP_IMM;
  assign is_lui = in_instr[6:0] == OPC_LUI;
  assign is_auipc = in_instr[6:0] == OPC_AUIPC;
  assign illegal = ~(is_op | is_imm | is_lui | is_auipc);
  assign d_we = ~illegal & (rd != 5'd0);
  reg_file #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk(clk), .rst_b(rst_b), .we(wb_en), .waddr(wb_rd), .wdata(wb_data),
    .raddr1(rs1), .raddr2(rs2), .rdata1(rdata1), .rdata2(rdata2)
  );
  always_comb begin
    d_op = is_op ? {in_instr[30], f3} : is_imm ? {(f3 == F3_SR) & in_instr[30], f3} : ALU_ADD;
    d_src1 = (is_op | is_imm) ? rdata1 : is_auipc ? in_pc : '0;
    d_src2 = is_op ? rdata2
           : is_imm ? XLEN'($signed(imm_i(in_instr[31:20])))
           : (is_lui | is_auipc) ? XLEN'($signed(imm_u(in_instr[31:12]))) : '0;
  end
  // A retiring writeback clears its busy bit in time for this cycle's hazard check.
  assign wb_clr = wb_en ? NREG'(1) << wb_rd : '0;
  assign pend = busy & ~wb_clr;
  assign hazard = ((is_op | is_imm) & pend[rs1]) | (is_op & pend[rs2]) | (d_we & pend[rd]);
  assign in_ready = (~out_valid | out_ready) & ~hazard;
  assign accept = in_valid & in_ready;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) busy <= '0;
    else busy <= (pend | ((accept && d_we) ? NREG'(1) << rd : '0)) & ~NREG'(1);
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      out_valid <= 1'b0;
      alu_opcode <= '0;
      alu_src1 <= '0;
      alu_src2 <= '0;
      out_rd <= '0;
      out_rd_we <= 1'b0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_opcode <= d_op;
      alu_src1 <= d_src1;
      alu_src2 <= d_src2;
      out_rd <= rd;
      out_rd_we <= d_we;
      out_illegal <= illegal;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed scoreboard bench for the decode/operand stage.
module tb_alu_operand_stage;
  typedef struct packed {
    logic [3:0] op;
    logic [31:0] s1, s2;
    logic [4:0] rd;
    logic we, ill;
  } exp_t;
  logic clk = 0, rst_b = 0, in_valid = 0, wb_en = 0, out_ready = 1;
  logic in_ready, out_valid, out_rd_we, out_illegal;
  logic [31:0] in_instr = 0, in_pc = 0, wb_data = 0, alu_src1, alu_src2;
  logic [4:0] wb_rd = 0, out_rd;
  logic [3:0] alu_opcode;
  logic [74:0] obs;
  exp_t sb[$];
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  assign obs = {alu_opcode, alu_src1, alu_src2, out_rd, out_rd_we, out_illegal};
  alu_operand_stage dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .alu_opcode(alu_opcode), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );
  function automatic exp_t mk(input logic [3:0] op, input logic [31:0] s1, s2,
                              input logic [4:0] rd, input logic we, ill);
    return {op, s1, s2, rd, we, ill};
  endfunction
  task automatic chk(input string tag, input logic [74:0] got, input logic [74:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got %h exp %h", tag, got, exp);
  endtask
  always @(negedge clk)
    if (rst_b && out_valid && out_ready) begin
      total++;
      assert (sb.size() != 0) passed++;
      else $error("FAIL sb_underflow got %h exp none", obs);
      if (sb.size() != 0) chk("out", obs, sb.pop_front());
    end
  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1; wb_rd = r; wb_data = d;
    @(posedge clk); #1 wb_en = 0;
  endtask
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
    bit ok = 0;
    in_valid = 1; in_instr = instr; in_pc = pc; sb.push_back(e);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    chk("accept", ok, 1);
    @(posedge clk); #1 in_valid = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_fields", obs, 0);
    chk("rst_busy", dut.busy, 0);
    chk("rst_ready", in_ready, 1);
    @(posedge clk); #1 rst_b = 1;
    wb(1, 5); wb(2, 3);
    send(32'h402081B3, 0, mk(4'b1000, 5, 3, 3, 1, 0));
    chk("busy3_set", dut.busy[3], 1);
    send(32'h4030D213, 0, mk(4'b1101, 5, 32'h403, 4, 1, 0));
    send(32'hFFF00413, 0, mk(4'b0000, 0, 32'hFFFFFFFF, 8, 1, 0));
    send(32'h002082B3, 0, mk(4'b0000, 5, 3, 5, 1, 0));
    in_valid = 1; in_instr = 32'h00128333; sb.push_back(mk(4'b0000, 8, 5, 6, 1, 0));
    repeat (3) begin
      @(negedge clk);
      chk("raw_stall_ready", in_ready, 0);
    end
    @(posedge clk); #1 wb_en = 1; wb_rd = 5; wb_data = 8;
    @(negedge clk);
    chk("wb_release_ready", in_ready, 1);
    chk("busy5_pre", dut.busy[5], 1);
    @(posedge clk); #1 wb_en = 0; in_valid = 0;
    chk("busy5_clr", dut.busy[5], 0);
    chk("busy6_set", dut.busy[6], 1);
    send(32'h12345397, 32'h80000000, mk(4'b0000, 32'h80000000, 32'h12345000, 7, 1, 0));
    drain();
    out_ready = 0;
    send(32'h002084B3, 0, mk(4'b0000, 5, 3, 9, 1, 0));
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_out", obs, mk(4'b0000, 5, 3, 9, 1, 0));
      chk("hold_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1;
    send(32'h00208033, 0, mk(4'b0000, 5, 3, 0, 0, 0));
    send(32'h0000007F, 0, mk(4'b0000, 0, 0, 0, 0, 1));
    drain();
    chk("busy_mask", dut.busy, 32'h000003D8);
    out_ready = 0;
    send(32'h00100513, 0, mk(4'b0000, 0, 1, 10, 1, 0));
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_busy3", dut.busy[3], 1);
    rst_b = 0;
    #2;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", dut.busy, 0);
    chk("mid_rst_x1", dut.u_rf.mem[1], 0);
    sb.delete();
    @(posedge clk); #1 rst_b = 1; out_ready = 1;
    send(32'h002081B3, 0, mk(4'b0000, 0, 0, 3, 1, 0));
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
